// File: rtl/redmule_w_buffer_ctrl.sv
// W-buffer controller: fills ROWS row slots from the streamer, then streams
// element/column/row-rotated read addresses for a configurable number of passes per tile.
module redmule_w_buffer_ctrl #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned ELMS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [15:0]                   cfg_tiles_i,
  input  logic [7:0]                    cfg_reps_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  output logic                          write_en_o,
  output logic [$clog2(ROWS)-1:0]       write_addr_o,
  input  logic                          rd_ready_i,
  output logic                          read_en_o,
  output logic [$clog2(ELMS)-1:0]       elms_read_addr_o,
  output logic [$clog2(COLS)-1:0]       cols_read_offs_o,
  output logic [ROWS*$clog2(ROWS)-1:0]  rows_read_addr_o,
  output logic                          rd_valid_o
);

  localparam int unsigned RAW = $clog2(ROWS);
  localparam int unsigned CAW = $clog2(COLS);
  localparam int unsigned EAW = $clog2(ELMS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_READ
  } state_e;

  state_e           r_state;
  state_e           w_next_state;

  logic [15:0]      r_tiles;
  logic [7:0]       r_reps;
  logic [15:0]      r_tile_cnt;
  logic [7:0]       r_pass_cnt;
  logic [RAW-1:0]   r_wcnt;
  logic [EAW-1:0]   r_elm;
  logic [CAW-1:0]   r_col;
  logic [RAW-1:0]   r_rot;
  logic             r_rd_valid;
  logic             r_done;

  logic             w_busy;
  logic             w_load_ready;
  logic             w_write_en;
  logic             w_read_en;
  logic             w_start_job;
  logic             w_start_zero;
  logic             w_last_write;
  logic             w_elm_wrap;
  logic             w_col_wrap;
  logic             w_last_pass;
  logic             w_tile_end;
  logic             w_last_tile;
  logic [ROWS*RAW-1:0] w_rows_addr;

  assign w_start_job  = (r_state == S_IDLE) & start_i & (cfg_tiles_i != 16'd0);
  assign w_start_zero = (r_state == S_IDLE) & start_i & (cfg_tiles_i == 16'd0);
  assign w_last_write = (r_wcnt == RAW'(ROWS - 1));
  assign w_elm_wrap   = (r_elm == EAW'(ELMS - 1));
  assign w_col_wrap   = (r_col == CAW'(COLS - 1));
  assign w_last_pass  = (r_pass_cnt == (r_reps - 8'd1));
  assign w_tile_end   = w_read_en & w_elm_wrap & w_col_wrap & w_last_pass;
  assign w_last_tile  = ((r_tile_cnt + 16'd1) == r_tiles);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // Next-state logic; clear_i overrides every other event
  always_comb begin
    // NOTE: defaulting first keeps every path assigned, so no latch is inferred.
    w_next_state = r_state;
    if (clear_i) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start_job) w_next_state = S_FILL;
        S_FILL: if (w_write_en && w_last_write) w_next_state = S_READ;
        S_READ: if (w_tile_end) w_next_state = w_last_tile ? S_IDLE : S_FILL;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    w_busy       = (r_state != S_IDLE);
    w_load_ready = (r_state == S_FILL);
    w_write_en   = load_valid_i & w_load_ready;
    w_read_en    = (r_state == S_READ) & rd_ready_i;
  end

  // Counters, config and registered strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tiles    <= '0;
      r_reps     <= '0;
      r_tile_cnt <= '0;
      r_pass_cnt <= '0;
      r_wcnt     <= '0;
      r_elm      <= '0;
      r_col      <= '0;
      r_rot      <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else if (clear_i) begin
      r_tiles    <= '0;
      r_reps     <= '0;
      r_tile_cnt <= '0;
      r_pass_cnt <= '0;
      r_wcnt     <= '0;
      r_elm      <= '0;
      r_col      <= '0;
      r_rot      <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= w_read_en;
      r_done     <= w_start_zero | (w_tile_end & w_last_tile);

      if (w_start_job) begin
        r_tiles    <= cfg_tiles_i;
        r_reps     <= (cfg_reps_i == 8'd0) ? 8'd1 : cfg_reps_i;
        r_tile_cnt <= '0;
      end

      if (w_write_en) begin
        r_wcnt <= r_wcnt + RAW'(1);
        if (w_last_write) begin
          r_elm      <= '0;
          r_col      <= '0;
          r_rot      <= '0;
          r_pass_cnt <= '0;
        end
      end

      // Element is innermost, then column, then pass with row rotation
      if (w_read_en) begin
        r_elm <= r_elm + EAW'(1);
        if (w_elm_wrap) begin
          r_col <= r_col + CAW'(1);
          if (w_col_wrap) begin
            if (w_last_pass) begin
              r_pass_cnt <= '0;
              r_rot      <= '0;
              r_tile_cnt <= r_tile_cnt + 16'd1;
            end else begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
              r_rot      <= r_rot + RAW'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_rows_addr = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_rows_addr[r*RAW +: RAW] = RAW'(r) + r_rot;
    end
  end

  assign busy_o           = w_busy;
  assign done_o           = r_done;
  assign load_ready_o     = w_load_ready;
  assign write_en_o       = w_write_en;
  assign write_addr_o     = r_wcnt;
  assign read_en_o        = w_read_en;
  assign elms_read_addr_o = r_elm;
  assign cols_read_offs_o = r_col;
  assign rows_read_addr_o = w_rows_addr;
  assign rd_valid_o       = r_rd_valid;

endmodule

// File: doc/redmule_w_buffer_ctrl.md
Name: redmule_w_buffer_ctrl

Overview:
- Control and address generator that drives the W-buffer latch array from both ends.
- On the write side it accepts W rows from the streamer and issues `write_en_o`/`write_addr_o`.
- On the read side it generates the per-cycle `elms_read_addr_o`, `cols_read_offs_o`, `rows_read_addr_o` and `read_en_o` for the datapath, repeating each tile for a configurable number of passes.
- Sits between the W streamer/scheduler and the W-buffer storage inside the RedMulE engine.

Parameters:
- ROWS, 4, number of W-buffer row slots (array height); ≥2, power of two
- COLS, 4, column groups per row slot; ≥2, power of two
- ELMS, 4, words per column group; ≥2, power of two

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clear_i  in  1  synchronous soft clear
- start_i  in  1  start job pulse; ignored while busy_o=1
- cfg_tiles_i  in  16  number of tiles in the job, sampled at start
- cfg_reps_i  in  8  read passes per tile, sampled at start; 0 is treated as 1
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse
- load_valid_i  in  1  W row available from the streamer
- load_ready_o  out  1  controller accepts a row
- write_en_o  out  1  buffer row write strobe
- write_addr_o  out  $clog2(ROWS)  target row slot
- rd_ready_i  in  1  datapath can consume a word per row this cycle
- read_en_o  out  1  read address strobe to the buffer
- elms_read_addr_o  out  $clog2(ELMS)  element index
- cols_read_offs_o  out  $clog2(COLS)  column offset
- rows_read_addr_o  out  ROWS*$clog2(ROWS)  per-row slot index
- rd_valid_o  out  1  buffer read data valid

Behaviour:
- Reset/interface: reset rst_ni, asynchronous, active-low; clock clk_i.
- Reset values: all outputs 0; all counters 0; state IDLE; `rows_read_addr_o[r]=r`.
- State IDLE:
  - `start_i` with cfg_tiles_i≠0 latches the config and moves to FILL.
  - `start_i` with cfg_tiles_i=0 pulses done_o on the next cycle and stays in IDLE.
- busy_o = (state≠IDLE).
- State FILL:
  - load_ready_o=1.
  - Combinational `write_en_o = load_valid_i & load_ready_o`; `write_addr_o = wcnt`.
  - wcnt increments on each write.
  - The ROWS-th write moves to READ the next cycle, with wcnt, elm, col and rot counters cleared.
- State READ:
  - Combinational `read_en_o = rd_ready_i`; load_ready_o=0.
  - Address outputs are registered and show the current address; they advance only on read_en_o.
  - elm counter increments 0..ELMS-1 (innermost); the col counter increments on elm wrap.
  - On col wrap: pass counter increments and `rot = (rot+1) mod ROWS`.
  - `rows_read_addr_o[r] = (r + rot) mod ROWS`.
- Tile end: the last read of the last pass (pass = reps-1) ends the tile.
  - Tile counter increments.
  - If more tiles remain → FILL with rot=0; otherwise → IDLE.
- rd_valid_o = read_en_o delayed by one cycle, matching the buffer's registered read addresses.
- done_o pulses in the cycle after the final read_en_o, i.e. coincident with the final rd_valid_o.
- Stalls:
  - rd_ready_i=0: read_en_o=0, all read addresses hold.
  - load_valid_i=0 in FILL: no write, wcnt holds.
- Outside READ the read addresses hold their last values.
- clear_i (priority over all events): next cycle state=IDLE, all counters and rot zeroed, rd_valid_o=0, no done_o, config discarded.
- Reset mid-job has the same effect as clear_i, but asynchronous.
- start_i while busy: ignored, no effect on the job.
- Counters are exact-width and wrap modulo 2^width. The tile counter is 16 bits and the pass counter 8 bits.

Test Plan (ROWS=COLS=ELMS=4):
1. Reset with all inputs 0 → all outputs 0, rows_read_addr_o={3,2,1,0} (index3..0), busy_o=0.
2. Single tile: tiles=1, reps=1, load_valid_i/rd_ready_i held 1 → write_addr_o 0,1,2,3 on 4 consecutive cycles. Then 16 reads: elms 0,1,2,3 per col, cols 0..3. rd_valid_o lags read_en_o by 1 cycle. done_o coincides with the 16th rd_valid_o.
3. Repeated passes: reps=2 → 32 reads. Second pass rows_read_addr_o[0..3]={1,2,3,0}. reps=0 behaves exactly like reps=1.
4. Backpressure:
   - Drop rd_ready_i for 3 cycles at elm=2, col=1 → read_en_o=0 and addresses frozen; the stream resumes at elm=2, col=1.
   - Toggle load_valid_i → write_addr_o advances only on strobes.
5. Multi-tile: tiles=2 → second FILL restarts write_addr_o at 0 and rot at 0. Total 8 writes and 32 reads; a single done_o pulse.
6. Clear and zero tiles:
   - clear_i asserted mid-READ → IDLE next cycle, no done_o, counters 0; a new start runs normally.
   - tiles=0 start → done_o one cycle later, no writes or reads.
